// File: rtl/nes_controller_responder_pkg.sv
// Shared types and constants for the NES controller responder.
// Holds the FSM state enum, button bit indices, shift length and timeout helper.
package nes_pkg;

    localparam int NES_BITS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE,
        LATCHED,
        SHIFT,
        DONE
    } nes_state_t;

    // Cycles of inClock in the allowed gap between pulse edges.
    function automatic logic [31:0] timeout_cycles(input longint base_hz,
                                                   input longint gap_us);
        return 32'((base_hz / 64'd1000000) * gap_us);
    endfunction

endpackage

// File: rtl/nes_controller_responder_if.sv
// Console-side NES pad bus: latch and pulse from the console, data back.
// master = console (drives latch/pulse), slave = pad responder (drives data).
interface nes_controller_responder_if;

    logic nesLatch;
    logic nesPulse;
    logic nesData;

    modport master (
        output nesLatch,
        output nesPulse,
        input  nesData
    );

    modport slave (
        input  nesLatch,
        input  nesPulse,
        output nesData
    );

endinterface

// File: rtl/nes_controller_responder_sync_edge.sv
// 2-flop synchronizer plus registered rise/fall detect for one async pin.
// Ports: inClock, reset (async low), pin in; level, rise, fall out.
module nes_sync_edge (
    input  logic inClock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // rise/fall are registered, so they appear 3 cycles after the pin moves.
    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= pin;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign level = s2;

endmodule

// File: rtl/nes_controller_responder.sv
// NES controller emulation: answers console latch/pulse with serial buttons.
// Ports: inClock, reset, buttons[7:0], bus (slave), shifting, pollCount[15:0].
module nes_controller_responder
    import nes_pkg::*;
#(
    parameter longint BASE_SPEED = 200000000,
    parameter longint TIMEOUT_US = 1000
) (
    input  logic                       inClock,
    input  logic                       reset,
    input  logic [NES_BITS-1:0]        buttons,
    nes_controller_responder_if.slave  bus,
    output logic                       shifting,
    output logic [15:0]                pollCount
);

    localparam logic [31:0] TIMEOUT_CYCLES =
        timeout_cycles(BASE_SPEED, TIMEOUT_US);

    localparam logic [3:0] LAST_IDX = 4'(NES_BITS - 1);

    nes_state_t          state;
    logic [NES_BITS-1:0] shreg;
    logic [3:0]          bitIdx;
    logic [31:0]         gap;
    logic                data_q;

    logic latch_lvl;
    logic latch_rise;
    logic latch_fall;
    logic pulse_lvl;
    logic pulse_rise;
    logic pulse_fall;

    nes_sync_edge u_latch (
        .inClock (inClock),
        .reset   (reset),
        .pin     (bus.nesLatch),
        .level   (latch_lvl),
        .rise    (latch_rise),
        .fall    (latch_fall)
    );

    nes_sync_edge u_pulse (
        .inClock (inClock),
        .reset   (reset),
        .pin     (bus.nesPulse),
        .level   (pulse_lvl),
        .rise    (pulse_rise),
        .fall    (pulse_fall)
    );

    // The latch level alone decides entry to LATCHED; bit 0 of shreg is
    // already on nesData by the time it would be read.
    logic unused_bits;
    assign unused_bits = ^{shreg[0], latch_rise, pulse_lvl};

    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= 8'hFF;
            bitIdx    <= '0;
            gap       <= '0;
            data_q    <= 1'b1;
            pollCount <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    data_q <= 1'b1;
                    gap    <= '0;
                    if (latch_lvl) begin
                        state <= LATCHED;
                    end
                end
                LATCHED: begin
                    shreg  <= buttons;
                    data_q <= ~buttons[BTN_A];
                    gap    <= '0;
                    if (latch_fall) begin
                        state     <= SHIFT;
                        bitIdx    <= '0;
                        pollCount <= pollCount + 16'd1;
                    end
                end
                SHIFT: begin
                    // Latch has priority; a coincident pulse is dropped.
                    if (latch_lvl) begin
                        state <= LATCHED;
                        gap   <= '0;
                    end else if (pulse_rise) begin
                        shreg  <= {1'b0, shreg[NES_BITS-1:1]};
                        bitIdx <= bitIdx + 4'd1;
                        gap    <= '0;
                        if (bitIdx == LAST_IDX) begin
                            state  <= DONE;
                            data_q <= 1'b1;
                        end else begin
                            data_q <= ~shreg[1];
                        end
                    end else if (pulse_fall) begin
                        gap <= '0;
                    end else if (gap >= TIMEOUT_CYCLES) begin
                        state  <= IDLE;
                        data_q <= 1'b1;
                    end else if (gap != '1) begin
                        gap <= gap + 32'd1;
                    end
                end
                DONE: begin
                    data_q <= 1'b1;
                    state  <= latch_lvl ? LATCHED : IDLE;
                end
                default: begin
                    state  <= IDLE;
                    data_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.nesData = data_q;
    assign shifting    = (state == SHIFT);

endmodule

// File: tb/tb_nes_controller_responder.sv
// Randomized bench for nes_controller_responder against a console-level model.
// Model: bit k after k pulses is ~buttons[k] (k<8) else 1; polls count mod 2^16.
module tb_nes_controller_responder;

    localparam longint BS  = 2000000;
    localparam longint TUS = 1000;
    localparam int     TO  = int'((BS / 1000000) * TUS);

    logic        clk;
    logic        rst_n;
    logic [7:0]  buttons;
    logic        shifting;
    logic [15:0] pollCount;

    int checks;
    int failures;
    int model_polls;

    nes_controller_responder_if bus ();

    nes_controller_responder #(
        .BASE_SPEED (BS),
        .TIMEOUT_US (TUS)
    ) dut (
        .inClock   (clk),
        .reset     (rst_n),
        .buttons   (buttons),
        .bus       (bus),
        .shifting  (shifting),
        .pollCount (pollCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k < 8) return ~b[k];
        return 1'b1;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int low_cycles);
        bus.nesPulse = 1'b1;
        cycles(6);
        bus.nesPulse = 1'b0;
        cycles(low_cycles);
    endtask

    // Latch a button set and start a read; checks LATCHED output and entry to SHIFT.
    task automatic start_read(input logic [7:0] b, input string tag);
        buttons      = b;
        bus.nesLatch = 1'b1;
        cycles(24);
        checks++;
        if (bus.nesData !== ~b[0]) begin
            failures++;
            $display("FAIL %s latched: nesData=%0b expected %0b",
                     tag, bus.nesData, ~b[0]);
        end
        bus.nesLatch = 1'b0;
        cycles(8);
        model_polls = (model_polls + 1) % 65536;
        checks++;
        if (shifting !== 1'b1 || pollCount !== 16'(model_polls)) begin
            failures++;
            $display("FAIL %s start: shifting=%0b poll=%0d expected 1 %0d",
                     tag, shifting, pollCount, model_polls);
        end
    endtask

    // Check bits first..last-1 in turn, pulsing after each.
    task automatic shift_bits(input logic [7:0] b, input int first,
                              input int last, input bit scramble,
                              input string tag);
        for (int k = first; k < last; k++) begin
            checks++;
            if (bus.nesData !== exp_bit(b, k)) begin
                failures++;
                $display("FAIL %s bit%0d: nesData=%0b expected %0b",
                         tag, k, bus.nesData, exp_bit(b, k));
            end
            if (scramble) buttons = 8'($urandom);
            pulse(6);
        end
    endtask

    task automatic full_read(input logic [7:0] b, input bit scramble,
                             input string tag);
        start_read(b, tag);
        shift_bits(b, 0, 8, scramble, tag);
        checks++;
        if (shifting !== 1'b0 || bus.nesData !== 1'b1) begin
            failures++;
            $display("FAIL %s end: shifting=%0b nesData=%0b expected 0 1",
                     tag, shifting, bus.nesData);
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        buttons      = 8'h00;
        bus.nesLatch = 1'b0;
        bus.nesPulse = 1'b0;
        model_polls  = 0;
        cycles(4);
        checks++;
        if (bus.nesData !== 1'b1 || shifting !== 1'b0 || pollCount !== 16'd0) begin
            failures++;
            $display("FAIL reset: data=%0b shifting=%0b poll=%0d expected 1 0 0",
                     bus.nesData, shifting, pollCount);
        end
        rst_n = 1'b1;
        cycles(4);
    endtask

    task automatic test_basic_read;
        full_read(8'b0000_1001, 1'b0, "basic");
        for (int i = 0; i < 4; i++) begin
            pulse(6);
            checks++;
            if (bus.nesData !== 1'b1 || shifting !== 1'b0) begin
                failures++;
                $display("FAIL extra_pulse%0d: data=%0b shifting=%0b expected 1 0",
                         i, bus.nesData, shifting);
            end
        end
    endtask

    task automatic test_random_reads;
        for (int i = 0; i < 4; i++) begin
            full_read(8'($urandom), 1'b1, "random");
        end
    endtask

    task automatic test_abort;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = 8'($urandom);
        start_read(a, "abort_a");
        shift_bits(a, 0, 3, 1'b0, "abort_a");
        buttons      = b;
        bus.nesLatch = 1'b1;
        bus.nesPulse = 1'b1;
        cycles(8);
        bus.nesPulse = 1'b0;
        checks++;
        if (shifting !== 1'b0 || bus.nesData !== ~b[0]) begin
            failures++;
            $display("FAIL abort: shifting=%0b data=%0b expected 0 %0b",
                     shifting, bus.nesData, ~b[0]);
        end
        full_read(b, 1'b0, "abort_b");
    endtask

    task automatic test_timeout;
        logic [7:0] b;
        b = 8'($urandom);
        start_read(b, "timeout");
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.nesData !== exp_bit(b, k)) begin
                failures++;
                $display("FAIL slow_bit%0d: data=%0b expected %0b",
                         k, bus.nesData, exp_bit(b, k));
            end
            pulse(TO * 3 / 4);
        end
        checks++;
        if (shifting !== 1'b1) begin
            failures++;
            $display("FAIL slow_pulses: shifting=%0b expected 1", shifting);
        end
        cycles(TO / 2);
        checks++;
        if (shifting !== 1'b0 || bus.nesData !== 1'b1) begin
            failures++;
            $display("FAIL timeout: shifting=%0b data=%0b expected 0 1",
                     shifting, bus.nesData);
        end
        pulse(6);
        checks++;
        if (shifting !== 1'b0 || bus.nesData !== 1'b1) begin
            failures++;
            $display("FAIL post_timeout: shifting=%0b data=%0b expected 0 1",
                     shifting, bus.nesData);
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [7:0] b;
        b = 8'($urandom) | 8'h20;
        start_read(b, "midrst");
        shift_bits(b, 0, 4, 1'b0, "midrst");
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_polls = 0;
        #1;
        checks++;
        if (bus.nesData !== 1'b1 || pollCount !== 16'd0 || shifting !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: data=%0b poll=%0d shifting=%0b expected 1 0 0",
                     bus.nesData, pollCount, shifting);
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
        full_read(8'($urandom), 1'b0, "after_rst");
    endtask

    task automatic test_wrap;
        rst_n = 1'b0;
        cycles(2);
        rst_n       = 1'b1;
        model_polls = 0;
        cycles(4);
        for (int i = 0; i < 65535; i++) begin
            bus.nesLatch = 1'b1;
            cycles(1);
            bus.nesLatch = 1'b0;
            cycles(2);
            model_polls = (model_polls + 1) % 65536;
        end
        cycles(8);
        checks++;
        if (pollCount !== 16'(model_polls)) begin
            failures++;
            $display("FAIL poll_max: poll=%0d expected %0d", pollCount, model_polls);
        end
        bus.nesLatch = 1'b1;
        cycles(1);
        bus.nesLatch = 1'b0;
        cycles(8);
        model_polls = (model_polls + 1) % 65536;
        checks++;
        if (pollCount !== 16'(model_polls)) begin
            failures++;
            $display("FAIL poll_wrap: poll=%0d expected %0d", pollCount, model_polls);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_read();
        test_random_reads();
        test_abort();
        test_timeout();
        test_reset_mid_shift();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
